// File: rtl/stream_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : stream_scoreboard
//  Description : In-order expected-vs-actual stream checker with masked
//                compare, saturating status counters and first-error capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [DATA_WIDTH-1:0]     exp_data,
    input  logic                      exp_vld,
    input  logic [DATA_WIDTH-1:0]     act_data,
    input  logic                      act_vld,
    input  logic [DATA_WIDTH-1:0]     cmp_mask,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      empty,
    output logic                      full,
    output logic [CNT_WIDTH-1:0]      pass_cnt,
    output logic [CNT_WIDTH-1:0]      fail_cnt,
    output logic [CNT_WIDTH-1:0]      ovf_cnt,
    output logic [CNT_WIDTH-1:0]      unf_cnt,
    output logic                      err_flag,
    output logic                      err_valid,
    output logic [CNT_WIDTH-1:0]      err_index,
    output logic [DATA_WIDTH-1:0]     err_exp,
    output logic [DATA_WIDTH-1:0]     err_act
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0]        LVL_ONE    = LW'(1);
    localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;
    logic                  err_flag_q, err_flag_d, err_valid_q, err_valid_d;
    logic [CNT_WIDTH-1:0]  err_index_q, err_index_d;
    logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d, err_act_q, err_act_d;

    logic                  w_pop, w_unf, w_push, w_ovf, w_match;
    logic [DATA_WIDTH-1:0] w_head;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        w_pop   = act_vld && !empty_q;
        w_unf   = act_vld && empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push  = exp_vld && (!full_q || w_pop);
        w_ovf   = exp_vld && full_q && !w_pop;
        w_head  = mem_q[rd_ptr_q];
        w_match = ((w_head ^ act_data) & cmp_mask) == '0;

        rd_ptr_d    = w_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d    = w_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        level_d     = level_q;
        if (w_push && !w_pop)      level_d = level_q + LVL_ONE;
        else if (w_pop && !w_push) level_d = level_q - LVL_ONE;
        empty_d     = (level_d == '0);
        full_d      = (level_d == FULL_LEVEL);

        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        ovf_cnt_d   = w_ovf ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
        unf_cnt_d   = w_unf ? sat_inc(unf_cnt_q) : unf_cnt_q;
        err_flag_d  = err_flag_q || w_ovf || w_unf;
        err_valid_d = err_valid_q;
        err_index_d = err_index_q;
        err_exp_d   = err_exp_q;
        err_act_d   = err_act_q;

        if (w_pop) begin
            if (w_match) begin
                pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                err_flag_d = 1'b1;
                if (!err_valid_q) begin
                    err_valid_d = 1'b1;
                    err_index_d = pass_cnt_q + fail_cnt_q;
                    err_exp_d   = w_head;
                    err_act_d   = act_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            ovf_cnt_q   <= '0;
            unf_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_index_q <= '0;
            err_exp_q   <= '0;
            err_act_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            unf_cnt_q   <= unf_cnt_d;
            err_flag_q  <= err_flag_d;
            err_valid_q <= err_valid_d;
            err_index_q <= err_index_d;
            err_exp_q   <= err_exp_d;
            err_act_q   <= err_act_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (w_push && !(reset || clear)) begin
            mem_q[wr_ptr_q] <= exp_data;
        end
    end

    assign level     = level_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign unf_cnt   = unf_cnt_q;
    assign err_flag  = err_flag_q;
    assign err_valid = err_valid_q;
    assign err_index = err_index_q;
    assign err_exp   = err_exp_q;
    assign err_act   = err_act_q;

endmodule
`default_nettype wire
